// File: rtl/match_lock_monitor_pkg.sv
// ---------------------------------------------------------------------------
// match_lock_pkg
// Shared types and constants for the match lock monitor.
//   lock_state_t : lock qualification FSM states
//   EVT_LOCK     : event code for a lock acquisition
//   EVT_LOSS     : event code for a lock loss
// ---------------------------------------------------------------------------
package match_lock_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    localparam logic EVT_LOCK = 1'b1;
    localparam logic EVT_LOSS = 1'b0;

endpackage

// File: rtl/match_lock_monitor_if.sv
// ---------------------------------------------------------------------------
// match_lock_monitor_if
// Bundles the match sample stream, the status outputs and the event
// valid/ready channel of the match lock monitor.
//   master : the environment (drives in_valid, match, evt_ready)
//   slave  : the monitor (drives locked, run_len, lock_cnt, evt_*)
// ---------------------------------------------------------------------------
interface match_lock_monitor_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             match;
    logic             locked;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] lock_cnt;
    logic             evt_valid;
    logic             evt_ready;
    logic             evt_code;
    logic             evt_ovf;

    modport master (
        output in_valid, match, evt_ready,
        input  locked, run_len, lock_cnt, evt_valid, evt_code, evt_ovf
    );

    modport slave (
        input  in_valid, match, evt_ready,
        output locked, run_len, lock_cnt, evt_valid, evt_code, evt_ovf
    );
endinterface

// File: rtl/match_lock_monitor_evt_slot.sv
// ---------------------------------------------------------------------------
// evt_slot
// Single-entry, fully registered valid/ready event holding register with a
// sticky overflow flag.
//   clk, rst   : clock, synchronous active-high reset
//   push       : a new event is offered this cycle
//   push_code  : code of the offered event
//   evt_ready  : consumer accepts the held event
//   evt_valid  : slot occupied
//   evt_code   : held event code (stable while evt_valid)
//   evt_ovf    : sticky, an event was dropped because the slot was full
// ---------------------------------------------------------------------------
module evt_slot (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_code,
    input  logic evt_ready,
    output logic evt_valid,
    output logic evt_code,
    output logic evt_ovf
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_code  <= 1'b0;
            evt_ovf   <= 1'b0;
        end else if (push) begin
            // A same-cycle accept frees the slot for the incoming event.
            if (!evt_valid || evt_ready) begin
                evt_valid <= 1'b1;
                evt_code  <= push_code;
            end else begin
                evt_ovf   <= 1'b1;
            end
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/match_lock_monitor.sv
// ---------------------------------------------------------------------------
// match_lock_monitor
// Qualifies a 1-bit comparator match stream into a lock/loss decision with
// hysteresis, counts the current match run and lock acquisitions, and
// reports each lock transition through a single-entry event slot.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : match_lock_monitor_if.slave
//          in:  in_valid, match, evt_ready
//          out: locked, run_len, lock_cnt, evt_valid, evt_code, evt_ovf
// ---------------------------------------------------------------------------
module match_lock_monitor
    import match_lock_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    match_lock_monitor_if.slave  bus
);

    localparam logic [CNT_W-1:0] LOCK_TH = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] LOSS_TH = CNT_W'(LOSS_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    lock_state_t      state_q, state_d;
    logic [CNT_W-1:0] hit_q,   hit_d;
    logic [CNT_W-1:0] miss_q,  miss_d;
    logic [CNT_W-1:0] run_q,   run_d;
    logic [CNT_W-1:0] lcnt_q,  lcnt_d;
    logic             push;
    logic             push_code;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        hit_d     = hit_q;
        miss_d    = miss_q;
        run_d     = run_q;
        lcnt_d    = lcnt_q;
        push      = 1'b0;
        push_code = EVT_LOCK;

        if (bus.in_valid) begin
            if (bus.match) begin
                run_d = (run_q == CNT_MAX) ? run_q : run_q + ONE;
            end else begin
                run_d = '0;
            end

            unique case (state_q)
                SEARCH: begin
                    hit_d = bus.match ? hit_q + ONE : '0;
                    // hit_q stays below LOCK_TH, so the increment cannot wrap.
                    if (bus.match && (hit_q + ONE == LOCK_TH)) begin
                        state_d   = LOCKED;
                        hit_d     = '0;
                        miss_d    = '0;
                        lcnt_d    = (lcnt_q == CNT_MAX) ? lcnt_q : lcnt_q + ONE;
                        push      = 1'b1;
                        push_code = EVT_LOCK;
                    end
                end
                LOCKED: begin
                    miss_d = bus.match ? '0 : miss_q + ONE;
                    if (!bus.match && (miss_q + ONE == LOSS_TH)) begin
                        state_d   = SEARCH;
                        hit_d     = '0;
                        miss_d    = '0;
                        push      = 1'b1;
                        push_code = EVT_LOSS;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEARCH;
            hit_q   <= '0;
            miss_q  <= '0;
            run_q   <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            run_q   <= run_d;
            lcnt_q  <= lcnt_d;
        end
    end

    assign bus.locked   = (state_q == LOCKED);
    assign bus.run_len  = run_q;
    assign bus.lock_cnt = lcnt_q;

    evt_slot u_evt_slot (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_code (push_code),
        .evt_ready (bus.evt_ready),
        .evt_valid (bus.evt_valid),
        .evt_code  (bus.evt_code),
        .evt_ovf   (bus.evt_ovf)
    );

endmodule

// File: tb/tb_match_lock_monitor.sv
// ---------------------------------------------------------------------------
// tb_match_lock_monitor
// Directed scenarios followed by randomized stimulus; every cycle the DUT
// outputs are compared with a sample-history reference model.
// ---------------------------------------------------------------------------
module tb_match_lock_monitor;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    match_lock_monitor_if #(.CNT_W(CNT_W)) bus ();

    match_lock_monitor #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: keeps the valid samples seen since the last lock
    // transition and decides lock/loss from the tail of that history.
    bit m_locked;
    int m_run;
    int m_locks;
    bit seg[$];
    bit ev_v, ev_c, ev_ovf;

    function automatic bit tail_is(input int n, input bit val);
        if (seg.size() < n) return 1'b0;
        for (int i = seg.size() - n; i < seg.size(); i++)
            if (seg[i] != val) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_update(input bit r, input bit v, input bit m, input bit rdy);
        bit push = 1'b0;
        bit code = 1'b0;
        if (r) begin
            m_locked = 0; m_run = 0; m_locks = 0; seg.delete();
            ev_v = 0; ev_c = 0; ev_ovf = 0;
            return;
        end
        if (v) begin
            m_run = m ? m_run + 1 : 0;
            seg.push_back(m);
            if (!m_locked && tail_is(LOCK_CNT, 1'b1)) begin
                m_locked = 1; m_locks++; seg.delete(); push = 1; code = 1;
            end else if (m_locked && tail_is(LOSS_CNT, 1'b0)) begin
                m_locked = 0; seg.delete(); push = 1; code = 0;
            end
        end
        if (push) begin
            if (!ev_v || rdy) begin ev_v = 1; ev_c = code; end
            else ev_ovf = 1;
        end else if (ev_v && rdy) begin
            ev_v = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        check("locked",    32'(bus.locked),    32'(m_locked));
        check("run_len",   32'(bus.run_len),   (m_run > CNT_MAX) ? CNT_MAX : m_run);
        check("lock_cnt",  32'(bus.lock_cnt),  (m_locks > CNT_MAX) ? CNT_MAX : m_locks);
        check("evt_valid", 32'(bus.evt_valid), 32'(ev_v));
        check("evt_code",  32'(bus.evt_code),  32'(ev_c));
        check("evt_ovf",   32'(bus.evt_ovf),   32'(ev_ovf));
    endtask

    // One clock: drive inputs, let the edge capture them, then compare 1ns later.
    task automatic step(input bit r, input bit v, input bit m, input bit rdy);
        rst          = r;
        bus.in_valid = v;
        bus.match    = m;
        bus.evt_ready = rdy;
        @(posedge clk);
        #1;
        model_update(r, v, m, rdy);
        compare_model();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.match     = 1'b0;
        bus.evt_ready = 1'b0;

        // Reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_locked",  32'(bus.locked),   0);
        check("rst_run_len", 32'(bus.run_len),  0);
        check("rst_evt_v",   32'(bus.evt_valid), 0);

        // Four matches acquire lock
        repeat (4) step(0, 1, 1, 1);
        check("s1_locked",   32'(bus.locked),    1);
        check("s1_evt_v",    32'(bus.evt_valid), 1);
        check("s1_evt_code", 32'(bus.evt_code),  1);
        check("s1_lock_cnt", 32'(bus.lock_cnt),  1);
        check("s1_run_len",  32'(bus.run_len),   4);

        // 3 matches, miss, 3 matches: no lock; one more match locks
        step(1, 0, 0, 1);
        repeat (3) step(0, 1, 1, 1);
        step(0, 1, 0, 1);
        repeat (3) step(0, 1, 1, 1);
        check("s2_no_lock", 32'(bus.locked),  0);
        check("s2_run_len", 32'(bus.run_len), 3);
        step(0, 1, 1, 1);
        check("s2_lock",    32'(bus.locked),  1);

        // Interrupted misses keep lock; third consecutive miss loses it
        step(0, 1, 0, 1); step(0, 1, 0, 1); step(0, 1, 1, 1);
        step(0, 1, 0, 1); step(0, 1, 0, 1);
        check("s3_hold", 32'(bus.locked), 1);
        step(0, 1, 0, 1);
        check("s3_loss",      32'(bus.locked),    0);
        check("s3_evt_v",     32'(bus.evt_valid), 1);
        check("s3_evt_code",  32'(bus.evt_code),  0);

        // in_valid gaps freeze counters
        step(1, 0, 0, 1);
        step(0, 1, 1, 1); step(0, 0, 0, 1);
        check("s4_frozen", 32'(bus.run_len), 1);
        step(0, 1, 1, 1); step(0, 0, 1, 1);
        step(0, 1, 1, 1); step(0, 0, 0, 1);
        check("s4_not_yet", 32'(bus.locked), 0);
        step(0, 1, 1, 1);
        check("s4_lock", 32'(bus.locked), 1);

        // Blocked consumer: loss event dropped, overflow sticky until rst
        step(1, 0, 0, 0);
        repeat (4) step(0, 1, 1, 0);
        repeat (3) step(0, 1, 0, 0);
        check("s5_locked",   32'(bus.locked),    0);
        check("s5_evt_v",    32'(bus.evt_valid), 1);
        check("s5_evt_code", 32'(bus.evt_code),  1);
        check("s5_ovf",      32'(bus.evt_ovf),   1);
        step(0, 0, 0, 1);
        check("s5_drained",  32'(bus.evt_valid), 0);
        check("s5_ovf_keep", 32'(bus.evt_ovf),   1);
        step(1, 0, 0, 0);
        check("s5_ovf_rst",  32'(bus.evt_ovf),   0);

        // Run length saturation, then reset mid-run
        repeat (300) step(0, 1, 1, 1);
        check("s6_sat", 32'(bus.run_len), 255);
        step(1, 1, 1, 1);
        check("s6_rst_run",  32'(bus.run_len),  0);
        check("s6_rst_lock", 32'(bus.locked),   0);
        check("s6_rst_lcnt", 32'(bus.lock_cnt), 0);
        check("s6_rst_ev",   32'(bus.evt_valid), 0);

        // Randomized stimulus against the model
        for (int i = 0; i < 2000; i++) begin
            int  bias = ((i / 250) % 2 == 1) ? 90 : 55;
            bit  r    = ($urandom_range(0, 299) == 0);
            bit  v    = ($urandom_range(0, 9) != 0);
            bit  m    = ($urandom_range(0, 99) < bias);
            bit  rdy  = ($urandom_range(0, 3) != 0);
            step(r, v, m, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
